// File: rtl/sha_req_arbiter.sv
// Round-robin front end that shares one sha_algo core among NUM_REQ requesters, one job in flight.
// Grant is combinational in IDLE; each stage waits on its partner's ready, and a stuck core is abandoned after TIMEOUT_CYCLES.
module sha_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                   clk_p,
  input  logic                   reset_p,
  input  logic [NUM_REQ*512-1:0] req_message_p,
  input  logic [NUM_REQ-1:0]     req_valid_p,
  output logic [NUM_REQ-1:0]     req_ready_p,
  output logic [255:0]           resp_hash_p,
  output logic [NUM_REQ-1:0]     resp_valid_p,
  input  logic [NUM_REQ-1:0]     resp_ready_p,
  output logic [511:0]           core_message_p,
  output logic                   core_message_valid_p,
  input  logic                   core_message_ready_p,
  input  logic [255:0]           core_hash_p,
  input  logic                   core_hash_valid_p,
  output logic                   core_hash_ready_p,
  output logic [ID_W-1:0]        grant_id_p,
  output logic                   busy_p,
  output logic                   timeout_p
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ID_W:0] NREQ = (ID_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [TW-1:0]   timer;
  logic [511:0]    msg_q;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W:0]   scan;
  logic [ID_W:0]   gnt_inc;
  logic [ID_W-1:0] rr_nxt;
  logic            expire;

  // Scan rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (scan >= NREQ) scan = scan - NREQ;
      if (!gnt_found && req_valid_p[scan[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[ID_W-1:0];
      end
    end
  end

  assign gnt_inc = {1'b0, gnt_idx} + 1'b1;
  assign rr_nxt  = (gnt_inc >= NREQ) ? '0 : gnt_inc[ID_W-1:0];
  assign expire  = (TIMEOUT_CYCLES != 0) && (timer == T_LAST);

  // Gated by reset so every output reads 0 while reset is held.
  assign req_ready_p    = (state == S_IDLE && reset_p && gnt_found) ? (ONE_HOT0 << gnt_idx) : '0;
  assign core_message_p = msg_q;

  always_ff @(posedge clk_p or negedge reset_p) begin
    if (!reset_p) begin
      state                <= S_IDLE;
      rr_ptr               <= '0;
      timer                <= '0;
      msg_q                <= '0;
      resp_hash_p          <= '0;
      resp_valid_p         <= '0;
      core_message_valid_p <= 1'b0;
      core_hash_ready_p    <= 1'b0;
      grant_id_p           <= '0;
      busy_p               <= 1'b0;
      timeout_p            <= 1'b0;
    end else begin
      timeout_p <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            msg_q                <= req_message_p[gnt_idx*512 +: 512];
            grant_id_p           <= gnt_idx;
            rr_ptr               <= rr_nxt;
            timer                <= '0;
            busy_p               <= 1'b1;
            core_message_valid_p <= 1'b1;
            state                <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= timer + 1'b1;
          if (expire) begin
            timeout_p            <= 1'b1;
            core_message_valid_p <= 1'b0;
            busy_p               <= 1'b0;
            state                <= S_IDLE;
          end else if (core_message_ready_p) begin
            core_message_valid_p <= 1'b0;
            core_hash_ready_p    <= 1'b1;
            state                <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // A hash landing on the expiry cycle still completes the job.
          if (core_hash_valid_p) begin
            resp_hash_p       <= core_hash_p;
            core_hash_ready_p <= 1'b0;
            resp_valid_p      <= ONE_HOT0 << grant_id_p;
            state             <= S_RESP;
          end else if (expire) begin
            timeout_p         <= 1'b1;
            core_hash_ready_p <= 1'b0;
            busy_p            <= 1'b0;
            state             <= S_IDLE;
          end
        end
        S_RESP: begin
          if (resp_ready_p[grant_id_p]) begin
            resp_valid_p <= '0;
            busy_p       <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_req_arbiter.sv
// Directed bench for sha_req_arbiter: table of full jobs plus timeout and mid-job reset sequences.
module tb_sha_req_arbiter;

  localparam int NR = 4;
  localparam logic [255:0] HASH_ABCD =
    256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

  logic              clk_p = 1'b0;
  logic              reset_p;
  logic [NR*512-1:0] req_message_p;
  logic [NR-1:0]     req_valid_p;
  logic [NR-1:0]     req_ready_p;
  logic [255:0]      resp_hash_p;
  logic [NR-1:0]     resp_valid_p;
  logic [NR-1:0]     resp_ready_p;
  logic [511:0]      core_message_p;
  logic              core_message_valid_p;
  logic              core_message_ready_p;
  logic [255:0]      core_hash_p;
  logic              core_hash_valid_p;
  logic              core_hash_ready_p;
  logic [1:0]        grant_id_p;
  logic              busy_p;
  logic              timeout_p;

  sha_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk_p(clk_p), .reset_p(reset_p),
    .req_message_p(req_message_p), .req_valid_p(req_valid_p), .req_ready_p(req_ready_p),
    .resp_hash_p(resp_hash_p), .resp_valid_p(resp_valid_p), .resp_ready_p(resp_ready_p),
    .core_message_p(core_message_p), .core_message_valid_p(core_message_valid_p),
    .core_message_ready_p(core_message_ready_p), .core_hash_p(core_hash_p),
    .core_hash_valid_p(core_hash_valid_p), .core_hash_ready_p(core_hash_ready_p),
    .grant_id_p(grant_id_p), .busy_p(busy_p), .timeout_p(timeout_p)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    logic [3:0]   rv;
    logic [1:0]   gnt;
    logic [255:0] hash;
    int           msg_wait;
    int           resp_wait;
  } vec_t;

  vec_t         vecs[12];
  logic [511:0] msgs[NR];
  int           n_chk  = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready_p, 0);
    chk({tag, "_resp_valid"}, resp_valid_p, 0);
    chk({tag, "_resp_hash"}, resp_hash_p, 0);
    chk({tag, "_msg_valid"}, core_message_valid_p, 0);
    chk({tag, "_msg"}, core_message_p, 0);
    chk({tag, "_hash_ready"}, core_hash_ready_p, 0);
    chk({tag, "_grant_id"}, grant_id_p, 0);
    chk({tag, "_busy"}, busy_p, 0);
    chk({tag, "_timeout"}, timeout_p, 0);
  endtask

  // One complete job: request, issue (optionally stalled), hash, response (optionally stalled).
  task automatic run_job(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.gnt;
    @(negedge clk_p);
    req_valid_p = v.rv;
    #1;
    chk("req_ready", req_ready_p, oh);
    chk("busy_idle", busy_p, 0);
    @(negedge clk_p); #1;
    chk("grant_id", grant_id_p, v.gnt);
    chk("busy", busy_p, 1);
    chk("msg_valid", core_message_valid_p, 1);
    chk("msg_data", core_message_p, msgs[v.gnt]);
    chk("no_grant_issue", req_ready_p, 0);
    for (int i = 0; i < v.msg_wait; i++) begin
      @(negedge clk_p); #1;
      chk("msg_hold_valid", core_message_valid_p, 1);
      chk("msg_hold_data", core_message_p, msgs[v.gnt]);
    end
    core_message_ready_p = 1'b1;
    @(negedge clk_p);
    core_message_ready_p = 1'b0;
    #1;
    chk("msg_valid_drop", core_message_valid_p, 0);
    chk("hash_ready", core_hash_ready_p, 1);
    chk("no_grant_wait", req_ready_p, 0);
    core_hash_p       = v.hash;
    core_hash_valid_p = 1'b1;
    @(negedge clk_p);
    core_hash_valid_p = 1'b0;
    core_hash_p       = '0;
    #1;
    chk("resp_valid", resp_valid_p, oh);
    chk("resp_hash", resp_hash_p, v.hash);
    chk("hash_ready_drop", core_hash_ready_p, 0);
    resp_ready_p = ~oh;
    for (int i = 0; i < v.resp_wait; i++) begin
      @(negedge clk_p); #1;
      chk("resp_hold_valid", resp_valid_p, oh);
      chk("resp_hold_hash", resp_hash_p, v.hash);
      chk("no_grant_resp", req_ready_p, 0);
    end
    resp_ready_p = 4'hF;
    @(negedge clk_p);
    resp_ready_p = '0;
    req_valid_p  = '0;
    #1;
    chk("resp_valid_drop", resp_valid_p, 0);
    chk("busy_drop", busy_p, 0);
  endtask

  initial begin
    vec_t r;
    int   tcnt;
    vecs[0]  = '{4'b0001, 2'd0, HASH_ABCD, 0, 0};
    vecs[1]  = '{4'b1111, 2'd1, {8{32'h1111_0001}}, 0, 0};
    vecs[2]  = '{4'b1111, 2'd2, {8{32'h2222_0002}}, 0, 0};
    vecs[3]  = '{4'b1111, 2'd3, {8{32'h3333_0003}}, 0, 0};
    vecs[4]  = '{4'b1111, 2'd0, {8{32'h4444_0004}}, 0, 0};
    vecs[5]  = '{4'b0101, 2'd2, {8{32'h5555_0005}}, 0, 0};
    vecs[6]  = '{4'b0011, 2'd0, {8{32'h6666_0006}}, 0, 0};
    vecs[7]  = '{4'b1000, 2'd3, {8{32'h7777_0007}}, 0, 0};
    vecs[8]  = '{4'b1010, 2'd1, {8{32'h8888_0008}}, 0, 0};
    vecs[9]  = '{4'b0001, 2'd0, {8{32'h9999_0009}}, 0, 0};
    vecs[10] = '{4'b0110, 2'd1, {8{32'haaaa_000a}}, 0, 10};
    vecs[11] = '{4'b1001, 2'd3, {8{32'hbbbb_000b}}, 5, 0};

    msgs[0] = '0;
    msgs[0][31:0]    = 32'h61626364;
    msgs[0][63:32]   = 32'h80000000;
    msgs[0][511:480] = 32'h00000020;
    for (int i = 1; i < NR; i++) msgs[i] = {16{8'(i), 24'hc0ffee}};
    for (int i = 0; i < NR; i++) req_message_p[i*512 +: 512] = msgs[i];

    reset_p              = 1'b0;
    req_valid_p          = 4'hF;
    resp_ready_p         = '0;
    core_message_ready_p = 1'b0;
    core_hash_p          = '0;
    core_hash_valid_p    = 1'b0;
    repeat (2) @(negedge clk_p);
    #1;
    chk_all_zero("reset");
    req_valid_p = '0;
    @(negedge clk_p);
    reset_p = 1'b1;

    for (int i = 0; i < 12; i++) run_job(vecs[i]);

    // Timeout: core takes the block but never returns a hash; req1 waits behind req0.
    @(negedge clk_p);
    req_valid_p = 4'b0011;
    #1;
    chk("to_req_ready", req_ready_p, 4'b0001);
    @(negedge clk_p); #1;
    chk("to_grant_id", grant_id_p, 0);
    core_message_ready_p = 1'b1;
    tcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_p);
      if (c == 1) core_message_ready_p = 1'b0;
      #1;
      if (c == 1) chk("to_in_wait", core_hash_ready_p, 1);
      if (timeout_p === 1'b1) begin
        tcnt = c;
        break;
      end
    end
    chk("to_pulse_cycle", tcnt, 16);
    chk("to_no_resp", resp_valid_p, 0);
    chk("to_busy", busy_p, 0);
    chk("to_hash_ready", core_hash_ready_p, 0);
    chk("to_next_ready", req_ready_p, 4'b0010);
    @(negedge clk_p); #1;
    chk("to_pulse_width", timeout_p, 0);
    chk("to_next_grant", grant_id_p, 1);
    chk("to_next_msg", core_message_p, msgs[1]);
    core_message_ready_p = 1'b1;
    @(negedge clk_p);
    core_message_ready_p = 1'b0;
    #1;
    chk("mid_in_wait", core_hash_ready_p, 1);

    // Reset asserted in WAIT, between clock edges.
    @(negedge clk_p);
    #2;
    reset_p = 1'b0;
    #1;
    chk_all_zero("midrst");
    req_valid_p = '0;
    repeat (2) @(negedge clk_p);
    reset_p = 1'b1;
    r = '{4'b0110, 2'd1, {8{32'hcccc_000c}}, 0, 0};
    run_job(r);
    r = '{4'b0100, 2'd2, {8{32'hdddd_000d}}, 0, 0};
    run_job(r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
